// File: rtl/rstack_pkg.sv
// Shared encodings for the J1 return-stack sequencer.
package rstack_pkg;

    typedef enum logic [1:0] {
        RD_NONE = 2'b00,
        RD_PUSH = 2'b01,
        RD_POP2 = 2'b10,
        RD_POP  = 2'b11
    } rdelta_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_OVF  = 2'b01,
        ERR_UNF  = 2'b10
    } err_e;

    typedef enum logic [1:0] {
        CLEAR = 2'b00,
        RUN   = 2'b01,
        FAULT = 2'b10
    } state_e;

endpackage

// File: rtl/rstack_ctrl.sv
// Return-stack pointer sequencer: decodes rdelta, guards over/underflow,
// and serially clears the stack RAM after reset or fault recovery.
module rstack_ctrl
    import rstack_pkg::*;
#(
    parameter int DW    = 16,
    parameter int AW    = 8,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_valid,
    input  logic [1:0]    cpu_rdelta,
    input  logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    output logic [DW-1:0] rsk_data,
    output logic [AW-1:0] rsp_n,
    output logic          rsk_wen,
    output logic [AW-1:0] rsp_q,
    output logic [AW-1:0] hwm,
    output logic [1:0]    err,
    input  logic          err_clr
);

    state_e        state, state_nxt;
    logic [AW-1:0] clr_cnt;
    logic [AW:0]   ptr_sum;
    logic          is_push, is_pop, is_pop2;
    logic          ovf, unf;

    // One extra pointer bit: any wrap past either end shows up in ptr_sum[AW].
    always_comb begin
        is_push = cpu_valid && (cpu_rdelta == RD_PUSH);
        is_pop  = cpu_valid && (cpu_rdelta == RD_POP);
        is_pop2 = cpu_valid && (cpu_rdelta == RD_POP2);
        ptr_sum = {1'b0, rsp_q};
        if (is_push)
            ptr_sum = {1'b0, rsp_q} + (AW+1)'(1);
        else if (is_pop)
            ptr_sum = {1'b0, rsp_q} - (AW+1)'(1);
        else if (is_pop2)
            ptr_sum = {1'b0, rsp_q} - (AW+1)'(2);
        ovf = is_push && ptr_sum[AW];
        unf = (is_pop || is_pop2) && ptr_sum[AW];
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= CLEAR;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_cnt == AW'(DEPTH-1)) state_nxt = RUN;
            RUN:     if (ovf || unf)              state_nxt = FAULT;
            FAULT:   if (err_clr)                 state_nxt = CLEAR;
            default:                              state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        cpu_stall = (state != RUN);
        rsk_data  = cpu_rdata;
        rsp_n     = rsp_q;
        rsk_wen   = 1'b0;
        case (state)
            CLEAR: begin
                rsk_data = '0;
                rsp_n    = clr_cnt;
                rsk_wen  = 1'b1;
            end
            RUN: begin
                if (!(ovf || unf)) begin
                    rsp_n   = ptr_sum[AW-1:0];
                    rsk_wen = is_push;
                end
            end
            default: ;
        endcase
        if (rst)
            rsk_wen = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt <= '0;
            rsp_q   <= '0;
            hwm     <= '0;
            err     <= ERR_NONE;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + AW'(1);
                    rsp_q   <= '0;
                    hwm     <= '0;
                end
                RUN: begin
                    if (ovf)
                        err <= ERR_OVF;
                    else if (unf)
                        err <= ERR_UNF;
                    else begin
                        rsp_q <= rsp_n;
                        if (is_push && rsp_n > hwm)
                            hwm <= rsp_n;
                    end
                end
                FAULT: begin
                    if (err_clr) begin
                        err     <= ERR_NONE;
                        clr_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rstack_ctrl.sv
// Self-checking bench for rstack_ctrl: abstract stack model checked every cycle
// plus directed scenarios with literal expectations.
module tb_rstack_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_valid;
    logic [1:0]  cpu_rdelta;
    logic [15:0] cpu_rdata;
    logic        cpu_stall;
    logic [15:0] rsk_data;
    logic [7:0]  rsp_n;
    logic        rsk_wen;
    logic [7:0]  rsp_q;
    logic [7:0]  hwm;
    logic [1:0]  err;
    logic        err_clr;

    rstack_ctrl #(.DW(16), .AW(8), .DEPTH(256)) dut (
        .clk(clk), .rst(rst),
        .cpu_valid(cpu_valid), .cpu_rdelta(cpu_rdelta), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall), .rsk_data(rsk_data), .rsp_n(rsp_n),
        .rsk_wen(rsk_wen), .rsp_q(rsp_q), .hwm(hwm), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int dval(input logic [1:0] r);
        case (r)
            2'b01:   return 1;
            2'b11:   return -1;
            2'b10:   return -2;
            default: return 0;
        endcase
    endfunction

    // Model: mode 0 clearing, 1 running, 2 faulted; sp is a plain integer stack depth.
    bit m_ok = 0;
    int m_mode, m_cnt, m_sp, m_hwm, m_err;

    always @(posedge clk) begin
        if (rst) begin
            m_ok <= 1; m_mode <= 0; m_cnt <= 0; m_sp <= 0; m_hwm <= 0; m_err <= 0;
        end else if (m_ok) begin
            case (m_mode)
                0: if (m_cnt == 255) begin m_mode <= 1; m_sp <= 0; m_hwm <= 0; end
                   else m_cnt <= m_cnt + 1;
                1: if (cpu_valid && dval(cpu_rdelta) != 0) begin
                       if (m_sp + dval(cpu_rdelta) > 255) begin m_err <= 1; m_mode <= 2; end
                       else if (m_sp + dval(cpu_rdelta) < 0) begin m_err <= 2; m_mode <= 2; end
                       else begin
                           m_sp <= m_sp + dval(cpu_rdelta);
                           if (dval(cpu_rdelta) == 1 && m_sp + 1 > m_hwm) m_hwm <= m_sp + 1;
                       end
                   end
                default: if (err_clr) begin m_mode <= 0; m_cnt <= 0; m_err <= 0; end
            endcase
        end
    end

    int c_t, c_n, c_w;
    always @(negedge clk) begin
        if (rst) chk("wen_in_reset", 32'(rsk_wen), 0);
        else if (m_ok) begin
            chk("stall", 32'(cpu_stall), (m_mode != 1) ? 1 : 0);
            chk("err", 32'(err), m_err);
            case (m_mode)
                0: begin
                    chk("clr_wen", 32'(rsk_wen), 1);
                    chk("clr_addr", 32'(rsp_n), m_cnt);
                    chk("clr_data", 32'(rsk_data), 0);
                end
                1: begin
                    c_t = m_sp + (cpu_valid ? dval(cpu_rdelta) : 0);
                    if (c_t != m_sp && c_t >= 0 && c_t <= 255) begin
                        c_n = c_t; c_w = (dval(cpu_rdelta) == 1) ? 1 : 0;
                    end else begin
                        c_n = m_sp; c_w = 0;
                    end
                    chk("run_rsp_n", 32'(rsp_n), c_n);
                    chk("run_wen", 32'(rsk_wen), c_w);
                    chk("run_data", 32'(rsk_data), 32'(cpu_rdata));
                    chk("run_rsp_q", 32'(rsp_q), m_sp);
                    chk("run_hwm", 32'(hwm), m_hwm);
                end
                default: begin
                    chk("flt_wen", 32'(rsk_wen), 0);
                    chk("flt_rsp_n", 32'(rsp_n), m_sp);
                    chk("flt_rsp_q", 32'(rsp_q), m_sp);
                    chk("flt_data", 32'(rsk_data), 32'(cpu_rdata));
                end
            endcase
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [1:0] d, input logic [15:0] data);
        cpu_valid = 1'b1; cpu_rdelta = d; cpu_rdata = data;
        cyc();
        cpu_valid = 1'b0;
    endtask

    task automatic recover();
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("rec_err0", 32'(err), 0);
        chk("rec_addr0", 32'(rsp_n), 0);
        repeat (256) cyc();
        chk("rec_stall", 32'(cpu_stall), 0);
        chk("rec_rsp_q", 32'(rsp_q), 0);
        chk("rec_hwm", 32'(hwm), 0);
    endtask

    logic [1:0] seq_d [8] = '{2'b01, 2'b01, 2'b00, 2'b11, 2'b01, 2'b01, 2'b10, 2'b11};

    initial begin
        rst = 1'b1; cpu_valid = 1'b0; cpu_rdelta = 2'b00; cpu_rdata = '0; err_clr = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        chk("post_rst_stall", 32'(cpu_stall), 1);
        chk("post_rst_err", 32'(err), 0);
        // Clear with stray cpu_valid pulses that must not leak into the RAM.
        for (int i = 0; i < 256; i++) begin
            cpu_valid = (i % 7 == 0); cpu_rdelta = 2'b01; cpu_rdata = 16'hBEEF;
            cyc();
        end
        cpu_valid = 1'b0;
        chk("clr_done_stall", 32'(cpu_stall), 0);
        chk("clr_done_rsp_q", 32'(rsp_q), 0);

        // Push / pop
        cpu_valid = 1'b1; cpu_rdelta = 2'b01; cpu_rdata = 16'h1234; #1;
        chk("push1_addr", 32'(rsp_n), 1);
        chk("push1_wen", 32'(rsk_wen), 1);
        cyc();
        cpu_rdata = 16'hABCD; #1;
        chk("push2_addr", 32'(rsp_n), 2);
        chk("push2_data", 32'(rsk_data), 32'h0000ABCD);
        cyc();
        cpu_valid = 1'b0;
        chk("push_rsp_q", 32'(rsp_q), 2);
        chk("push_hwm", 32'(hwm), 2);
        op(2'b10, 16'h0);
        chk("pop2_rsp_q", 32'(rsp_q), 0);
        chk("pop2_hwm", 32'(hwm), 2);

        // Overflow
        for (int i = 0; i < 255; i++) op(2'b01, 16'(i));
        chk("full_rsp_q", 32'(rsp_q), 255);
        chk("full_hwm", 32'(hwm), 255);
        cpu_valid = 1'b1; cpu_rdelta = 2'b01; cpu_rdata = 16'h7777; #1;
        chk("ovf_wen", 32'(rsk_wen), 0);
        chk("ovf_nostall", 32'(cpu_stall), 0);
        cyc();
        cpu_valid = 1'b0;
        chk("ovf_err", 32'(err), 1);
        chk("ovf_stall", 32'(cpu_stall), 1);
        chk("ovf_rsp_q", 32'(rsp_q), 255);
        recover();

        // Underflow pop at 0 with a simultaneous err_clr: fault wins, ack must repeat.
        err_clr = 1'b1;
        op(2'b11, 16'h0);
        err_clr = 1'b0;
        chk("unf_err", 32'(err), 2);
        chk("unf_stall", 32'(cpu_stall), 1);
        cyc();
        chk("unf_held", 32'(err), 2);
        recover();

        // pop2 at depth 1, then recover with a reset at clr_cnt=100.
        op(2'b01, 16'h0055);
        op(2'b10, 16'h0);
        chk("unf2_err", 32'(err), 2);
        chk("unf2_rsp_q", 32'(rsp_q), 1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        repeat (100) cyc();
        chk("mid_addr100", 32'(rsp_n), 100);
        rst = 1'b1; #1;
        chk("mid_rst_wen", 32'(rsk_wen), 0);
        cyc();
        rst = 1'b0;
        chk("mid_restart", 32'(rsp_n), 0);
        cpu_valid = 1'b1; cpu_rdelta = 2'b01; cpu_rdata = 16'hDEAD;
        repeat (255) cyc();
        cpu_valid = 1'b0;
        chk("mid_last_addr", 32'(rsp_n), 255);
        chk("mid_last_stall", 32'(cpu_stall), 1);
        cyc();
        chk("mid_done_stall", 32'(cpu_stall), 0);
        chk("mid_done_rsp_q", 32'(rsp_q), 0);

        // Mixed traffic, checked by the model.
        for (int i = 0; i < 8; i++) begin
            cpu_valid = (seq_d[i] != 2'b00); cpu_rdelta = seq_d[i]; cpu_rdata = 16'(16'h100 + i);
            cyc();
        end
        cpu_valid = 1'b0;
        chk("mix_rsp_q", 32'(rsp_q), 0);
        chk("mix_hwm", 32'(hwm), 3);
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rstack_ctrl.md
Name: rstack_ctrl

Overview:
Sequencer for the J1 return stack. Decodes the CPU's per-instruction return-stack delta into the next pointer, write enable and write data for the stack RAM, and guards against overflow and underflow. After reset it also clears the stack RAM serially, one entry per cycle, instead of using a 256-way parallel clear. It sits between the J1 core decode and return_stack, and stalls the core while clearing or faulted.

Parameters:
DW, 16, data width of a stack entry
AW, 8, pointer width
DEPTH, 256, number of entries; must equal 2**AW

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cpu_valid  in  1  instruction issued this cycle
cpu_rdelta  in  2  00 none, 01 push(+1), 11 pop(-1), 10 pop2(-2)
cpu_rdata  in  DW  value to push (return address or T)
cpu_stall  out  1  core must hold its instruction
rsk_data  out  DW  write data to stack RAM
rsp_n  out  AW  next pointer / write address to stack RAM
rsk_wen  out  1  stack RAM write strobe
rsp_q  out  AW  current pointer (registered)
hwm  out  AW  high-water mark of rsp_q since last clear
err  out  2  sticky fault: 01 overflow, 10 underflow, 00 none
err_clr  in  1  acknowledge fault, restart via CLEAR

Behaviour:
- Reset: state is CLEAR, clr_cnt=0, rsp_q=0, hwm=0, err=00. cpu_stall=1 from the first cycle after reset.
- Reset asserted mid-operation (any state, any clr_cnt) aborts it and behaves as above. No RAM write occurs in a cycle where rst=1.
- CLEAR state:
  - rsk_wen=1, rsk_data=0, rsp_n=clr_cnt; clr_cnt increments each cycle.
  - After writing address DEPTH-1, the next state is RUN, with rsp_q=0 and hwm=0.
  - Duration is exactly DEPTH cycles; cpu_stall=1 throughout.
  - cpu_valid is ignored.
- RUN state: cpu_stall=0. All outputs below are combinational from the cpu_* inputs and rsp_q, so a push is written in the issue cycle (zero latency). rsp_q <= rsp_n at the clock edge.
  - cpu_valid=0 or delta 00: rsp_n=rsp_q, rsk_wen=0.
  - push (01): rsp_n=rsp_q+1, rsk_wen=1, rsk_data=cpu_rdata.
  - pop (11): rsp_n=rsp_q-1, rsk_wen=0.
  - pop2 (10): rsp_n=rsp_q-2, rsk_wen=0.
  - rsk_data=cpu_rdata whenever not clearing, whether or not rsk_wen is asserted.
- Overflow: push with rsp_q==DEPTH-1.
- Underflow: pop with rsp_q==0, or pop2 with rsp_q<2.
- Fault handling:
  - The faulting instruction is suppressed: rsk_wen=0, rsp_n=rsp_q.
  - err is loaded with the fault code; next state is FAULT.
  - The core is not stalled in the faulting cycle, because the stall is registered.
  - Arithmetic never wraps. Pointer math is AW+1 bits wide, so wrap-around is detected rather than taken.
- FAULT state: cpu_stall=1, rsk_wen=0, rsp_n=rsp_q, err held. err_clr=1 moves to CLEAR, and err returns to 00 on entry to CLEAR. err_clr is ignored in other states.
- hwm: in RUN, hwm <= max(hwm, rsp_n) on every accepted push.
- Simultaneous events:
  - rst has priority over everything.
  - err_clr in the same cycle as a new fault: the fault is latched first (the FAULT entry cycle), and err_clr must be reasserted.

Decomposition:
Shared package rstack_pkg holds:
- the delta encodings RD_NONE/RD_PUSH/RD_POP/RD_POP2
- the err codes ERR_NONE/ERR_OVF/ERR_UNF
- the state enum CLEAR/RUN/FAULT
No sub-module is needed: the pointer/guard arithmetic and the FSM are one compact block. Instantiate rstack_ctrl beside return_stack and wire rsk_data, rsp_n and rsk_wen directly across.

Test Plan:
1. Reset clear: deassert rst -> rsk_wen=1 with rsp_n=0..255 on consecutive cycles, rsk_data=0 throughout, cpu_stall=1 for 256 cycles, then 0 with rsp_q=0.
2. Push/pop: push 0x1234 then 0xABCD -> writes at rsp_n=1 and 2, rsp_q=2, hwm=2. pop2 -> rsp_q=0, no writes, hwm stays 2.
3. Overflow: 255 pushes reach rsp_q=255; a 256th push -> rsk_wen=0, err=01, cpu_stall=1 on the next cycle, rsp_q stays 255.
4. Underflow: pop with rsp_q=0 -> err=10. Separately, pop2 with rsp_q=1 -> err=10, rsp_q stays 1.
5. Recovery: from FAULT, err_clr=1 -> 256-cycle clear, err=00, rsp_q=0, hwm=0, stall released.
6. Mid-clear reset: assert rst at clr_cnt=100 -> clear restarts at address 0 and completes 256 cycles later. Also check cpu_valid pulses during CLEAR produce no cpu_rdata writes.
